// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the program-counter / return-address-stack block.
//   op_t      : operation encoding presented on pc_ras.op
//   FLG_*     : bit positions inside the 4-bit status flag vector
//   OP_W      : width of the op field
//   FLAG_W    : width of the flag vector
// ---------------------------------------------------------------------------
package pc_pkg;

  localparam int OP_W   = 3;
  localparam int FLAG_W = 4;

  typedef enum logic [OP_W-1:0] {
    NEXT = 3'd0,
    REL  = 3'd1,
    ABS  = 3'd2,
    CALL = 3'd3,
    RET  = 3'd4
  } op_t;

  localparam logic [1:0] FLG_ZERO  = 2'd0;
  localparam logic [1:0] FLG_NEG   = 2'd1;
  localparam logic [1:0] FLG_CARRY = 2'd2;
  localparam logic [1:0] FLG_OVF   = 2'd3;

endpackage : pc_pkg

// File: rtl/ras_stack.sv
// ---------------------------------------------------------------------------
// ras_stack
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry and keeps the occupancy saturated at DEPTH. The top entry is
// read combinationally, so a value pushed on one edge is visible as `top`
// in the very next cycle.
//
// Ports
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset (clears pointer and occupancy)
//   push   : write din at the stack pointer, advance pointer
//   pop    : retreat pointer (ignored while empty)
//   din    : value to push
//   top    : most recently pushed valid entry
//   depth  : number of valid entries (0..DEPTH)
//   full   : depth == DEPTH
//   empty  : depth == 0
// ---------------------------------------------------------------------------
module ras_stack
  import pc_pkg::*;
#(
  parameter int D     = 12,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [D-1:0]               din,
  output logic [D-1:0]               top,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  // Entry storage; contents are don't-care after reset, only the
  // occupancy count decides what is visible.
  logic [D-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] sp_r;
  logic [CNT_W-1:0] cnt_r;
  logic [PTR_W-1:0] top_idx_s;

  assign full      = (cnt_r == CNT_W'(DEPTH));
  assign empty     = (cnt_r == {CNT_W{1'b0}});
  assign depth     = cnt_r;
  // sp_r points at the next free slot; DEPTH is a power of two so the
  // subtraction wraps around the ring naturally.
  assign top_idx_s = sp_r - PTR_W'(1);
  assign top       = mem_r[top_idx_s];

  // Stack pointer and occupancy counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_r  <= {PTR_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else if (push) begin
      sp_r <= sp_r + PTR_W'(1);
      // On a full stack the write lands on the oldest slot; count saturates.
      if (!full) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else if (pop && !empty) begin
      sp_r  <= sp_r - PTR_W'(1);
      cnt_r <= cnt_r - CNT_W'(1);
    end
  end

  // Entry write port.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_r[sp_r] <= din;
    end
  end

endmodule : ras_stack

// File: rtl/pc_ras.sv
// ---------------------------------------------------------------------------
// pc_ras
// Program counter with conditional relative/absolute branches and a
// call/return stack. Every update lands on the next rising clock edge.
//
// Ports
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset, dominates stall and op
//   stall    : hold all state (op and err_clr ignored)
//   op       : NEXT / REL / ABS / CALL / RET, other codes behave as NEXT
//   flags    : {overflow, carry, negative, zero}
//   cond_sel : which flag forms the branch condition
//   cond_inv : invert the selected flag
//   uncond   : force the branch condition true
//   target   : REL offset (two's complement) or ABS/CALL address
//   err_clr  : clear sticky error flags (a same-cycle new error wins)
//   prog_ctr : current program counter
//   depth    : valid return-stack entries
//   err_ovf  : sticky, set by CALL on a full stack
//   err_unf  : sticky, set by a taken RET on an empty stack
// ---------------------------------------------------------------------------
module pc_ras
  import pc_pkg::*;
#(
  parameter int D     = 12,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic [2:0]                 op,
  input  logic [3:0]                 flags,
  input  logic [1:0]                 cond_sel,
  input  logic                       cond_inv,
  input  logic                       uncond,
  input  logic [D-1:0]               target,
  input  logic                       err_clr,
  output logic [D-1:0]               prog_ctr,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       err_ovf,
  output logic                       err_unf
);

  logic [D-1:0] pc_r;
  logic         err_ovf_r;
  logic         err_unf_r;

  op_t          op_s;
  logic         take_s;
  logic [D-1:0] pc_plus1_s;
  logic [D-1:0] pc_nxt_s;
  logic         push_s;
  logic         pop_s;
  logic         ovf_set_s;
  logic         unf_set_s;
  logic         ovf_nxt_s;
  logic         unf_nxt_s;

  logic [D-1:0] stk_top_s;
  logic         stk_full_s;
  logic         stk_empty_s;
  logic         stk_push_s;
  logic         stk_pop_s;

  assign op_s       = op_t'(op);
  assign take_s     = uncond | (flags[cond_sel] ^ cond_inv);
  // Both the plain increment and the REL add wrap modulo 2^D.
  assign pc_plus1_s = pc_r + D'(1);

  // Next-PC selection and stack/error requests for the current op.
  always_comb begin
    pc_nxt_s  = pc_plus1_s;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    ovf_set_s = 1'b0;
    unf_set_s = 1'b0;
    case (op_s)
      NEXT: begin
        pc_nxt_s = pc_plus1_s;
      end
      REL: begin
        if (take_s) begin
          pc_nxt_s = pc_r + target;
        end else begin
          pc_nxt_s = pc_plus1_s;
        end
      end
      ABS: begin
        if (take_s) begin
          pc_nxt_s = target;
        end else begin
          pc_nxt_s = pc_plus1_s;
        end
      end
      CALL: begin
        if (take_s) begin
          pc_nxt_s  = target;
          push_s    = 1'b1;
          ovf_set_s = stk_full_s;
        end else begin
          pc_nxt_s = pc_plus1_s;
        end
      end
      RET: begin
        if (take_s && !stk_empty_s) begin
          pc_nxt_s = stk_top_s;
          pop_s    = 1'b1;
        end else if (take_s) begin
          // Nothing to return to: fall through and flag it.
          pc_nxt_s  = pc_plus1_s;
          unf_set_s = 1'b1;
        end else begin
          pc_nxt_s = pc_plus1_s;
        end
      end
      default: begin
        pc_nxt_s = pc_plus1_s;
      end
    endcase
  end

  // A new error outranks a simultaneous clear.
  assign ovf_nxt_s = (err_ovf_r & ~err_clr) | ovf_set_s;
  assign unf_nxt_s = (err_unf_r & ~err_clr) | unf_set_s;

  // Stall freezes the stack together with the rest of the state.
  assign stk_push_s = push_s & ~stall;
  assign stk_pop_s  = pop_s & ~stall;

  // Program counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r      <= {D{1'b0}};
      err_ovf_r <= 1'b0;
      err_unf_r <= 1'b0;
    end else if (!stall) begin
      pc_r      <= pc_nxt_s;
      err_ovf_r <= ovf_nxt_s;
      err_unf_r <= unf_nxt_s;
    end
  end

  ras_stack #(
    .D     (D),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (stk_push_s),
    .pop   (stk_pop_s),
    .din   (pc_plus1_s),
    .top   (stk_top_s),
    .depth (depth),
    .full  (stk_full_s),
    .empty (stk_empty_s)
  );

  assign prog_ctr = pc_r;
  assign err_ovf  = err_ovf_r;
  assign err_unf  = err_unf_r;

endmodule : pc_ras

// File: tb/tb_pc_ras.sv
// ---------------------------------------------------------------------------
// tb_pc_ras
// Directed self-checking bench for pc_ras (D=12, DEPTH=8).
// ---------------------------------------------------------------------------
module tb_pc_ras;
  import pc_pkg::*;

  localparam int D     = 12;
  localparam int DEPTH = 8;

  logic         clk;
  logic         reset;
  logic         stall;
  logic [2:0]   op;
  logic [3:0]   flags;
  logic [1:0]   cond_sel;
  logic         cond_inv;
  logic         uncond;
  logic [D-1:0] target;
  logic         err_clr;
  logic [D-1:0] prog_ctr;
  logic [3:0]   depth;
  logic         err_ovf;
  logic         err_unf;

  int n_total;
  int n_pass;

  pc_ras #(.D(D), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .op       (op),
    .flags    (flags),
    .cond_sel (cond_sel),
    .cond_inv (cond_inv),
    .uncond   (uncond),
    .target   (target),
    .err_clr  (err_clr),
    .prog_ctr (prog_ctr),
    .depth    (depth),
    .err_ovf  (err_ovf),
    .err_unf  (err_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Set up one operation, clock it in, leave defaults on the other inputs.
  task automatic do_op(input logic [2:0] o, input logic u, input logic [D-1:0] t);
    op     = o;
    uncond = u;
    target = t;
    step();
  endtask

  initial begin
    n_total  = 0;
    n_pass   = 0;
    reset    = 1'b1;
    stall    = 1'b0;
    op       = 3'(NEXT);
    flags    = 4'h0;
    cond_sel = FLG_ZERO;
    cond_inv = 1'b0;
    uncond   = 1'b0;
    target   = 12'h000;
    err_clr  = 1'b0;
    step();
    step();
    chk("rst_pc", 32'(prog_ctr), 32'h0);
    chk("rst_depth", 32'(depth), 32'h0);
    chk("rst_ovf", 32'(err_ovf), 32'h0);
    chk("rst_unf", 32'(err_unf), 32'h0);

    // Three NEXT cycles: 1, 2, 3.
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      do_op(3'(NEXT), 1'b0, 12'h000);
      chk("next_seq", 32'(prog_ctr), 32'(i));
    end

    // REL taken on zero flag: 10 + (-2) = 8.
    do_op(3'(ABS), 1'b1, 12'd10);
    chk("abs_10", 32'(prog_ctr), 32'd10);
    flags    = 4'b0001;
    cond_sel = FLG_ZERO;
    do_op(3'(REL), 1'b0, 12'hFFE);
    chk("rel_taken", 32'(prog_ctr), 32'd8);
    // Same with inverted condition: not taken -> 11.
    do_op(3'(ABS), 1'b1, 12'd10);
    cond_inv = 1'b1;
    do_op(3'(REL), 1'b0, 12'hFFE);
    chk("rel_inv", 32'(prog_ctr), 32'd11);
    cond_inv = 1'b0;

    // ABS conditioned on carry flag.
    flags    = 4'b0100;
    cond_sel = FLG_CARRY;
    do_op(3'(ABS), 1'b0, 12'h040);
    chk("abs_carry", 32'(prog_ctr), 32'h040);
    // CALL with false condition just increments, no push.
    flags = 4'h0;
    do_op(3'(CALL), 1'b0, 12'h123);
    chk("call_nt_pc", 32'(prog_ctr), 32'h041);
    chk("call_nt_dep", 32'(depth), 32'h0);

    // CALL then RET back-to-back.
    do_op(3'(ABS), 1'b1, 12'h005);
    do_op(3'(CALL), 1'b1, 12'h100);
    chk("call_pc", 32'(prog_ctr), 32'h100);
    chk("call_dep", 32'(depth), 32'h1);
    do_op(3'(RET), 1'b1, 12'h000);
    chk("ret_pc", 32'(prog_ctr), 32'h006);
    chk("ret_dep", 32'(depth), 32'h0);

    // Nine nested calls from pc=6: call i jumps to 0x200+0x10*i.
    for (int i = 0; i < 9; i++) begin
      do_op(3'(CALL), 1'b1, 12'(12'h200 + 16 * i));
      chk("nest_pc", 32'(prog_ctr), 32'h200 + 32'(16 * i));
      chk("nest_dep", 32'(depth), (i + 1 > DEPTH) ? 32'(DEPTH) : 32'(i + 1));
      chk("nest_ovf", 32'(err_ovf), (i == 8) ? 32'h1 : 32'h0);
    end
    // Returns: pushes of calls 8..1, i.e. 0x271 down to 0x201.
    for (int k = 0; k < 8; k++) begin
      do_op(3'(RET), 1'b1, 12'h000);
      chk("unwind_pc", 32'(prog_ctr), 32'h271 - 32'(16 * k));
      chk("unwind_dep", 32'(depth), 32'(7 - k));
    end
    chk("ovf_sticky", 32'(err_ovf), 32'h1);
    err_clr = 1'b1;
    do_op(3'(NEXT), 1'b0, 12'h000);
    err_clr = 1'b0;
    chk("ovf_clr", 32'(err_ovf), 32'h0);
    chk("ovf_clr_pc", 32'(prog_ctr), 32'h202);

    // Underflow.
    do_op(3'(ABS), 1'b1, 12'h020);
    do_op(3'(RET), 1'b1, 12'h000);
    chk("unf_pc", 32'(prog_ctr), 32'h021);
    chk("unf_set", 32'(err_unf), 32'h1);
    chk("unf_dep", 32'(depth), 32'h0);
    err_clr = 1'b1;
    do_op(3'(NEXT), 1'b0, 12'h000);
    chk("unf_clr", 32'(err_unf), 32'h0);
    do_op(3'(RET), 1'b1, 12'h000);
    chk("unf_win", 32'(err_unf), 32'h1);
    chk("unf_win_pc", 32'(prog_ctr), 32'h023);

    // Stall with CALL and err_clr: nothing changes.
    stall = 1'b1;
    do_op(3'(CALL), 1'b1, 12'h300);
    stall   = 1'b0;
    err_clr = 1'b0;
    chk("stall_pc", 32'(prog_ctr), 32'h023);
    chk("stall_dep", 32'(depth), 32'h0);
    chk("stall_unf", 32'(err_unf), 32'h1);

    // Wrap of increment and of REL add.
    do_op(3'(ABS), 1'b1, 12'hFFF);
    do_op(3'(NEXT), 1'b0, 12'h000);
    chk("wrap_next", 32'(prog_ctr), 32'h000);
    do_op(3'(ABS), 1'b1, 12'hFFE);
    do_op(3'(REL), 1'b1, 12'h003);
    chk("wrap_rel", 32'(prog_ctr), 32'h001);

    // Reset together with CALL, after one entry was pushed.
    do_op(3'(ABS), 1'b1, 12'h050);
    do_op(3'(CALL), 1'b1, 12'h060);
    chk("pre_rst_dep", 32'(depth), 32'h1);
    reset = 1'b1;
    do_op(3'(CALL), 1'b1, 12'h070);
    reset = 1'b0;
    chk("rstcall_pc", 32'(prog_ctr), 32'h000);
    chk("rstcall_dep", 32'(depth), 32'h0);
    chk("rstcall_unf", 32'(err_unf), 32'h0);
    // No entry survives: RET underflows.
    do_op(3'(RET), 1'b1, 12'h000);
    chk("post_rst_pc", 32'(prog_ctr), 32'h001);
    chk("post_rst_unf", 32'(err_unf), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_pc_ras

// File: doc/pc_ras.md
PC_RAS -- requirements
Module: pc_ras

Interface
REQ-001 Parameter D, default 12, program-counter and target width in bits.
REQ-002 Parameter DEPTH, default 8, return-address stack entries (power of 2, >=2).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  freeze all state this cycle.
REQ-006 op  input  3  operation: NEXT, REL, ABS, CALL, RET (others treated as NEXT).
REQ-007 flags  input  4  status flags: [0] zero, [1] negative, [2] carry, [3] overflow.
REQ-008 cond_sel  input  2  index into flags for the branch condition.
REQ-009 cond_inv  input  1  invert the selected flag.
REQ-010 uncond  input  1  force condition true.
REQ-011 target  input  D  REL: two's-complement offset; ABS/CALL: absolute address.
REQ-012 err_clr  input  1  clear sticky error flags.
REQ-013 prog_ctr  output  D  current program counter.
REQ-014 depth  output  $clog2(DEPTH+1)  valid stack entries.
REQ-015 err_ovf  output  1  sticky stack-overflow flag.
REQ-016 err_unf  output  1  sticky stack-underflow flag.

Function
REQ-017 take SHALL be uncond | (flags[cond_sel] ^ cond_inv), evaluated combinationally each cycle.
REQ-018 stall=1 SHALL hold prog_ctr, stack contents, depth and error flags; op is ignored. err_clr is also ignored.
REQ-019 NEXT, or any op with take=0, SHALL give prog_ctr <= prog_ctr+1.
REQ-020 REL with take SHALL give prog_ctr <= prog_ctr+target, modulo 2^D.
REQ-021 ABS with take SHALL give prog_ctr <= target.
REQ-022 CALL with take SHALL push prog_ctr+1 (mod 2^D) and set prog_ctr <= target, both in the same edge.
REQ-023 CALL while depth==DEPTH SHALL overwrite the oldest entry (circular), keep depth at DEPTH, still jump, and set err_ovf.
REQ-024 RET with take and depth>0 SHALL give prog_ctr <= top entry and depth-1.
REQ-025 RET with take and depth==0 SHALL give prog_ctr <= prog_ctr+1, leave depth at 0, and set err_unf.
REQ-026 All updates SHALL take effect on the next rising edge (latency 1); the new prog_ctr is visible the cycle after op.
REQ-027 Increment and add SHALL wrap silently: 2^D-1 -> 0.
REQ-028 err_clr SHALL clear both sticky flags. A new error in the same cycle SHALL win and leave its flag set.
REQ-029 The top of stack SHALL be readable the cycle after a push, so back-to-back CALL then RET returns correctly.

Reset
REQ-030 reset SHALL dominate stall and op.
REQ-031 reset SHALL clear prog_ctr, depth, err_ovf and err_unf to 0.
REQ-032 Stack RAM contents are don't-care after reset; reset mid-CALL leaves no pushed entry visible.

Structure
REQ-033 Package pc_pkg SHALL hold the op enum (NEXT=0, REL=1, ABS=2, CALL=3, RET=4) and the flag index constants FLG_ZERO..FLG_OVF.
REQ-034 A sub-module ras_stack (push, pop, data in, top, depth, full, empty; circular pointer) SHALL implement the stack.
REQ-035 The ras_stack instance SHALL be parametrised by D and DEPTH.

Verification
REQ-036 Reset then 3 NEXT cycles -> prog_ctr 0,1,2,3.
REQ-037 prog_ctr=10, REL, target=12'hFFE, flags[0]=1, cond_sel=0 -> prog_ctr=8; same with cond_inv=1 -> 11.
REQ-038 prog_ctr=5, CALL target=0x100 uncond -> prog_ctr=0x100, depth=1; then RET uncond -> prog_ctr=6, depth=0.
REQ-039 Nine nested CALLs with DEPTH=8 -> err_ovf=1, depth=8. Eight RETs then return the addresses of the last eight calls in LIFO order.
REQ-040 RET on empty stack at prog_ctr=0x20 -> prog_ctr=0x21, err_unf=1. err_clr then clears it; err_clr together with another empty RET keeps err_unf=1.
REQ-041 stall high during CALL -> no change. prog_ctr=12'hFFF with NEXT -> 0. reset asserted together with CALL -> prog_ctr=0, depth=0.
